fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the 16-bit, 5-stage pipeline. It responds to the hazard unit's stall, flush and redirect outputs (`pc_wen`, `if_id_wen`, `if_id_flush`, `control_hazard`) and owns the PC. It runs a one-outstanding-request handshake with a variable-latency instruction memory and drives the IF/ID pipeline register. The block also absorbs memory responses that arrive during a stall, squashes stale fetches on redirect, and stops fetching on HLT.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0000, encoding inserted as a bubble (ADD $0,$0,$0).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_wen`  in  1  0 = hold PC (hazard stall).
- `if_id_wen`  in  1  0 = hold IF/ID outputs (hazard stall).
- `if_id_flush`  in  1  1 = load bubble into IF/ID.
- `control_hazard`  in  1  1 = redirect PC to `branch_target`.
- `branch_target`  in  16  redirect address.
- `imem_req`  out  1  request strobe, one cycle per request.
- `imem_addr`  out  16  request address, valid while `imem_req`=1.
- `imem_valid`  in  1  response strobe, at least 1 cycle after the request.
- `imem_rdata`  in  16  instruction, valid with `imem_valid`.
- `if_id_instr`  out  16  IF/ID instruction.
- `if_id_pc_plus2`  out  16  address of `if_id_instr` + 2.
- `if_id_valid`  out  1  0 = bubble.
- `fetch_stall`  out  1  high in WAIT when `imem_valid`=0.

## Operation
- States:
  - ISSUE: `imem_req`=1, `imem_addr`=pc; goes to WAIT next cycle.
  - WAIT: a request is outstanding.
  - HOLD: one-entry buffer is full.
  - HALTED: no requests.
- `imem_req` is combinational from state and forced to 0 while `rst`=0. `imem_valid` is ignored outside WAIT.
- `advance` = `pc_wen` & `if_id_wen`.
- WAIT with `imem_valid`=1 and squash=0:
  - If `advance`=1: `if_id_instr`<=rdata, `if_id_pc_plus2`<=pc+2, `if_id_valid`<=1, pc<=pc+2. Next state is HALTED if rdata[15:12]==4'hF, else ISSUE.
  - If `advance`=0: rdata goes to the buffer; next state HOLD.
- WAIT with `imem_valid`=1 and squash=1: data discarded, squash cleared, next state ISSUE.
- HOLD with `advance`=1: the buffer transfers to the outputs exactly as the WAIT case above, with the same next-state rule.
- Any cycle in which no instruction transfers and `if_id_wen`=1: outputs load the bubble (NOP_INSTR, valid 0, pc_plus2 0).
- `if_id_flush`=1: outputs load the bubble regardless of `if_id_wen`. The pending instruction is not lost unless `control_hazard` is also high.
- `control_hazard`=1 takes priority over `pc_wen` and over every state:
  - pc<=`branch_target`; the buffer is invalidated.
  - A response in the same cycle is discarded.
  - In WAIT with no response this cycle: squash<=1 and the state stays WAIT. Otherwise next state is ISSUE, including from HALTED.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000.

## Timing
- Reset values:
  - pc=RESET_PC, state=ISSUE, squash=0, buffer empty.
  - `if_id_instr`=NOP_INSTR, `if_id_pc_plus2`=0, `if_id_valid`=0.
  - `imem_req`=0, `fetch_stall`=0.
- First request is in the first cycle after `rst` deasserts.
- With 1-cycle memory latency: ISSUE at cycle N, response at N+1, outputs valid after edge N+1, next ISSUE at N+2. Throughput is one instruction per 2 cycles.
- Latency L: outputs update at the edge of cycle N+L, and `fetch_stall`=1 for L-1 cycles.
- Asserting reset in any state aborts immediately. A late response after reset arrives in ISSUE and is ignored.
- At most one request is outstanding; no new request is issued before a squashed response returns.
- Simultaneous flush + redirect: bubble output, PC=target, pending data dropped.

## Test plan
- Reset, 1-cycle memory with mem[0]=16'h1234, mem[2]=16'h5678 -> `imem_addr` 0000 then 0002; `if_id_instr`=1234, `if_id_pc_plus2`=0002, valid=1; then 5678 / 0004. Bubbles in between.
- Response arrives with `if_id_wen`=`pc_wen`=0 held for 3 cycles -> outputs unchanged, no `imem_req`. On release, the buffered instruction appears next edge and the next request goes to pc+2.
- 3-cycle latency, `control_hazard`=1 with target 16'h0040 one cycle after the request -> the stale response is discarded with `if_id_valid`=0. Next `imem_addr`=0040.
- `if_id_flush`=1 while valid instruction 16'hA00F is held -> next cycle `if_id_instr`=0000, `if_id_valid`=0.
- Fetch 16'hF000 -> delivered with valid=1, then no `imem_req` for 10 cycles. `control_hazard` to 16'h0100 resumes at 0100.
- RESET_PC=16'hFFFE -> second address is 0000. Assert `rst` in WAIT with latency 3 -> outputs reset immediately, and the late `imem_valid` is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding request to a
// variable-latency instruction memory, and drives the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_wen,
  input  logic        if_id_wen,
  input  logic        if_id_flush,
  input  logic        control_hazard,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        fetch_stall
);

  localparam int unsigned XLEN    = 16;
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam logic [3:0]  HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    S_ISSUE  = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              squash_q, squash_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pcp2_q, pcp2_d;
  logic              valid_q, valid_d;

  logic              advance;
  logic              xfer;
  logic [XLEN-1:0]   xfer_instr;
  logic [XLEN-1:0]   pc_plus2;

  // A flush holds back the pending instruction rather than consuming it.
  assign advance  = pc_wen & if_id_wen & ~if_id_flush;
  assign pc_plus2 = pc_q + XLEN'(2);

  // Next-state, PC and IF/ID payload.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    squash_d   = squash_q;
    buf_d      = buf_q;
    instr_d    = instr_q;
    pcp2_d     = pcp2_q;
    valid_d    = valid_q;
    xfer       = 1'b0;
    xfer_instr = buf_q;

    if (control_hazard) begin
      pc_d = branch_target;
      if ((state_q == S_WAIT) && !imem_valid) begin
        squash_d = 1'b1;
      end else begin
        state_d  = S_ISSUE;
        squash_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = S_ISSUE;
            end else if (advance) begin
              xfer       = 1'b1;
              xfer_instr = imem_rdata;
            end else begin
              buf_d   = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (advance) begin
            xfer       = 1'b1;
            xfer_instr = buf_q;
          end
        end
        S_HALTED: state_d = S_HALTED;
      endcase
    end

    if (xfer) begin
      pc_d    = pc_plus2;
      state_d = (xfer_instr[OP_MSB:OP_LSB] == HALT_OP) ? S_HALTED : S_ISSUE;
    end

    if (if_id_flush || (!xfer && if_id_wen)) begin
      instr_d = NOP_INSTR;
      pcp2_d  = '0;
      valid_d = 1'b0;
    end else if (xfer) begin
      instr_d = xfer_instr;
      pcp2_d  = pc_plus2;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_ISSUE;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      buf_q    <= '0;
      instr_q  <= NOP_INSTR;
      pcp2_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      buf_q    <= buf_d;
      instr_q  <= instr_d;
      pcp2_q   <= pcp2_d;
      valid_q  <= valid_d;
    end
  end

  // A redirect during ISSUE suppresses the strobe so no orphan request is left in flight.
  assign imem_req       = rst & (state_q == S_ISSUE) & ~control_hazard;
  assign imem_addr      = pc_q;
  assign fetch_stall    = (state_q == S_WAIT) & ~imem_valid;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus2 = pcp2_q;
  assign if_id_valid    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model checks
// request addresses, and a monitor checks every instruction delivered to IF/ID.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_wen = 1'b1;
  logic        if_id_wen = 1'b1;
  logic        if_id_flush = 1'b0;
  logic        control_hazard = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        fetch_stall;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcp2;
  } deliv_t;

  deliv_t      exp_q[$];
  logic [15:0] addr_q[$];
  logic [15:0] mem [logic [15:0]];
  int          lat = 1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_wen         (pc_wen),
    .if_id_wen      (if_id_wen),
    .if_id_flush    (if_id_flush),
    .control_hazard (control_hazard),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .fetch_stall    (fetch_stall)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_d(input logic [15:0] instr, input logic [15:0] pcp2);
    deliv_t e;
    e.instr = instr;
    e.pcp2  = pcp2;
    exp_q.push_back(e);
  endtask

  // Memory model and delivery monitor share one process.
  initial begin
    logic        req_s;
    logic        wen_s;
    logic [15:0] a_s;
    bit          pend;
    int          cnt;
    logic [15:0] pdata;
    deliv_t      e;
    pend  = 1'b0;
    cnt   = 0;
    pdata = 16'h0000;
    forever begin
      @(posedge clk);
      req_s = imem_req;
      a_s   = imem_addr;
      wen_s = if_id_wen;
      #1;
      if (rst && if_id_valid && wen_s) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver: got instr %h pc_plus2 %h expected no delivery", if_id_instr, if_id_pc_plus2);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_instr", if_id_instr, e.instr);
          chk("deliver_pc_plus2", if_id_pc_plus2, e.pcp2);
        end
      end
      imem_valid = 1'b0;
      if (req_s) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL imem_addr: got request %h expected no request", a_s);
        end else begin
          chk("imem_addr", a_s, addr_q.pop_front());
        end
        pend  = 1'b1;
        cnt   = lat;
        pdata = mem.exists(a_s) ? mem[a_s] : 16'h0000;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = pdata;
          pend       = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && addr_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d deliveries and %0d addresses pending, expected 0",
               name, exp_q.size(), addr_q.size());
      exp_q.delete();
      addr_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (if_id_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: if_id_valid got 0 expected 1 within 50 cycles", name);
    end
  endtask

  task automatic redirect(input logic [15:0] t);
    @(negedge clk);
    control_hazard = 1'b1;
    branch_target  = t;
    @(negedge clk);
    control_hazard = 1'b0;
  endtask

  initial begin
    int nreq;
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'h5678;
    mem[16'h0004] = 16'hF000;
    mem[16'h0100] = 16'h1111;
    mem[16'h0102] = 16'h2222;
    mem[16'h0104] = 16'hF001;
    mem[16'h0020] = 16'h3333;
    mem[16'h0040] = 16'hF002;
    mem[16'h0050] = 16'hA00F;
    mem[16'h0052] = 16'hF003;
    mem[16'hFFFE] = 16'h7777;
    mem[16'h0060] = 16'hBEEF;
    mem[16'h0062] = 16'hC0DE;

    // Reset state and straight-line fetch up to HLT.
    #3;
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_pc_plus2", if_id_pc_plus2, 16'h0000);
    chk("rst_valid", 16'(if_id_valid), 16'h0000);
    chk("rst_req", 16'(imem_req), 16'h0000);
    chk("rst_stall", 16'(fetch_stall), 16'h0000);
    addr_q = '{16'h0000, 16'h0002, 16'h0004};
    push_d(16'h1234, 16'h0002);
    push_d(16'h5678, 16'h0004);
    push_d(16'hF000, 16'h0006);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_req", 16'(imem_req), 16'h0001);
    chk("first_addr", imem_addr, 16'h0000);
    wait_valid("first_delivery");
    @(posedge clk);
    #1;
    chk("bubble_valid", 16'(if_id_valid), 16'h0000);
    chk("bubble_instr", if_id_instr, 16'h0000);
    wait_idle("straight_fetch");
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nreq += int'(imem_req);
    end
    chk("halted_req_count", 16'(nreq), 16'h0000);
    chk("halted_valid", 16'(if_id_valid), 16'h0000);

    // Resume from HLT and stall across a response.
    addr_q = '{16'h0100, 16'h0102, 16'h0104};
    push_d(16'h1111, 16'h0102);
    push_d(16'h2222, 16'h0104);
    push_d(16'hF001, 16'h0106);
    redirect(16'h0100);
    wait_valid("resume_delivery");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc_wen    = 1'b0;
      if_id_wen = 1'b0;
      chk("stall_instr", if_id_instr, 16'h1111);
      chk("stall_valid", 16'(if_id_valid), 16'h0001);
      if (i > 0) chk("stall_no_req", 16'(imem_req), 16'h0000);
    end
    @(negedge clk);
    chk("stall_last_instr", if_id_instr, 16'h1111);
    chk("stall_last_req", 16'(imem_req), 16'h0000);
    pc_wen    = 1'b1;
    if_id_wen = 1'b1;
    @(posedge clk);
    #1;
    chk("release_instr", if_id_instr, 16'h2222);
    wait_idle("stall_buffer");

    // Redirect one cycle after a 3-cycle-latency request squashes it.
    lat = 3;
    addr_q = '{16'h0020, 16'h0040};
    push_d(16'hF002, 16'h0042);
    redirect(16'h0020);
    @(negedge clk);
    chk("squash_stall_w1", 16'(fetch_stall), 16'h0001);
    control_hazard = 1'b1;
    branch_target  = 16'h0040;
    @(negedge clk);
    control_hazard = 1'b0;
    chk("squash_stall_w2", 16'(fetch_stall), 16'h0001);
    chk("squash_req_w2", 16'(imem_req), 16'h0000);
    wait_idle("squash");

    // Flush while a valid instruction is held.
    lat = 1;
    addr_q = '{16'h0050, 16'h0052};
    push_d(16'hA00F, 16'h0052);
    push_d(16'hF003, 16'h0054);
    redirect(16'h0050);
    wait_valid("flush_delivery");
    @(negedge clk);
    pc_wen      = 1'b0;
    if_id_wen   = 1'b0;
    if_id_flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_instr", if_id_instr, 16'h0000);
    chk("flush_valid", 16'(if_id_valid), 16'h0000);
    chk("flush_pc_plus2", if_id_pc_plus2, 16'h0000);
    @(negedge clk);
    pc_wen      = 1'b1;
    if_id_wen   = 1'b1;
    if_id_flush = 1'b0;
    wait_idle("flush");

    // PC wraps from FFFE to 0000.
    addr_q = '{16'hFFFE, 16'h0000, 16'h0002, 16'h0004};
    push_d(16'h7777, 16'h0000);
    push_d(16'h1234, 16'h0002);
    push_d(16'h5678, 16'h0004);
    push_d(16'hF000, 16'h0006);
    redirect(16'hFFFE);
    wait_idle("wrap");

    // Reset mid-WAIT with a late response that must be ignored.
    addr_q = '{16'h0060, 16'h0062};
    push_d(16'hBEEF, 16'h0062);
    redirect(16'h0060);
    wait_valid("pre_reset_delivery");
    @(negedge clk);
    lat       = 3;
    pc_wen    = 1'b0;
    if_id_wen = 1'b0;
    @(negedge clk);
    chk("pre_reset_instr", if_id_instr, 16'hBEEF);
    chk("pre_reset_stall", 16'(fetch_stall), 16'h0001);
    rst = 1'b0;
    #1;
    chk("async_rst_instr", if_id_instr, 16'h0000);
    chk("async_rst_valid", 16'(if_id_valid), 16'h0000);
    chk("async_rst_pc_plus2", if_id_pc_plus2, 16'h0000);
    chk("async_rst_req", 16'(imem_req), 16'h0000);
    chk("async_rst_stall", 16'(fetch_stall), 16'h0000);
    addr_q = '{16'h0000, 16'h0002, 16'h0004};
    push_d(16'h1234, 16'h0002);
    push_d(16'h5678, 16'h0004);
    push_d(16'hF000, 16'h0006);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    pc_wen    = 1'b1;
    if_id_wen = 1'b1;
    wait_idle("reset_refetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
